// File: rtl/mdu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// mdu_issue_arbiter
//
// Shares the single mdu_pipeline issue port between REQ_COUNT MDU issue
// queues. At most one requester is granted per cycle and its fields are
// forwarded to the pipeline combinationally (zero added latency, no
// buffering). Winner selection, highest priority first:
//   1. starvation protection (a requester that lost STARVE_LIMIT cycles in a row)
//   2. divider-pairing affinity (same DIV/REM signedness and source PRs as the
//      last issued divide, so the pipeline can reuse the divider result)
//   3. round-robin from rr_ptr
// Every scan starts at rr_ptr and wraps from REQ_COUNT-1 to 0.
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   req_valid[i]                requester i holds an op
//   req_op[i]                   MDU op; bit2 = divide/remainder, bit0 = unsigned
//   req_A/B_forward, _is_zero   operand flags, valid only in the request cycle
//   req_A_PR, req_B_PR          full source physical registers
//   req_dest_PR, req_ROB_index  destination PR and ROB index
//   req_ready[i]                one-hot grant; the op is consumed this cycle
//   issue_*                     winner's fields to the pipeline (0 with no grant)
//   issue_A_PR, issue_B_PR      register-bank bits (low bits) of the winner's PRs
//   issue_ready                 pipeline accepts an issue this cycle
//   affinity_hits               saturating count of grants decided by affinity
// -----------------------------------------------------------------------------
module mdu_issue_arbiter #(
    parameter int REQ_COUNT          = 2,
    parameter int STARVE_LIMIT       = 6,
    parameter int WAIT_W             = 3,
    parameter int LOG_PR_COUNT       = 7,
    parameter int LOG_ROB_ENTRIES    = 6,
    parameter int LOG_PRF_BANK_COUNT = 2
) (
    input  logic                                          CLK,
    input  logic                                          RST,

    input  logic [REQ_COUNT-1:0]                          req_valid,
    input  logic [REQ_COUNT-1:0][2:0]                     req_op,
    input  logic [REQ_COUNT-1:0]                          req_A_forward,
    input  logic [REQ_COUNT-1:0]                          req_A_is_zero,
    input  logic [REQ_COUNT-1:0]                          req_B_forward,
    input  logic [REQ_COUNT-1:0]                          req_B_is_zero,
    input  logic [REQ_COUNT-1:0][LOG_PR_COUNT-1:0]        req_A_PR,
    input  logic [REQ_COUNT-1:0][LOG_PR_COUNT-1:0]        req_B_PR,
    input  logic [REQ_COUNT-1:0][LOG_PR_COUNT-1:0]        req_dest_PR,
    input  logic [REQ_COUNT-1:0][LOG_ROB_ENTRIES-1:0]     req_ROB_index,
    output logic [REQ_COUNT-1:0]                          req_ready,

    output logic                                          issue_valid,
    output logic [2:0]                                    issue_op,
    output logic                                          issue_A_forward,
    output logic                                          issue_A_is_zero,
    output logic [LOG_PRF_BANK_COUNT-1:0]                 issue_A_PR,
    output logic                                          issue_B_forward,
    output logic                                          issue_B_is_zero,
    output logic [LOG_PRF_BANK_COUNT-1:0]                 issue_B_PR,
    output logic [LOG_PR_COUNT-1:0]                       issue_dest_PR,
    output logic [LOG_ROB_ENTRIES-1:0]                    issue_ROB_index,
    input  logic                                          issue_ready,

    output logic [15:0]                                   affinity_hits
);

    localparam int PTR_W = (REQ_COUNT > 2) ? 2 : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]                      rr_ptr;
    logic [REQ_COUNT-1:0][WAIT_W-1:0]      wait_cnt;
    logic                                  last_div_valid;
    logic                                  last_div_unsigned;
    logic [LOG_PR_COUNT-1:0]               last_div_A_PR;
    logic [LOG_PR_COUNT-1:0]               last_div_B_PR;

    // ------------------------------------------------------------------
    // Candidate vectors
    // ------------------------------------------------------------------
    logic [REQ_COUNT-1:0] eligible;
    logic [REQ_COUNT-1:0] starved;
    logic [REQ_COUNT-1:0] affine;
    logic [REQ_COUNT-1:0] grant;
    logic                 grant_valid;
    logic                 by_affinity;
    logic [PTR_W-1:0]     win_idx;
    logic [PTR_W-1:0]     rr_next;
    logic [LOG_PR_COUNT-1:0] win_A_PR;
    logic [LOG_PR_COUNT-1:0] win_B_PR;

    // One-hot of the first set bit of cand, scanning upward from ptr with wrap.
    function automatic logic [REQ_COUNT-1:0] first_from_ptr(
        input logic [REQ_COUNT-1:0] cand,
        input logic [PTR_W-1:0]     ptr
    );
        logic [REQ_COUNT-1:0] sel;
        logic                 done;
        logic [PTR_W:0]       idx;
        sel  = '0;
        done = 1'b0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(REQ_COUNT))
                idx = idx - (PTR_W+1)'(REQ_COUNT);
            if (!done && cand[idx[PTR_W-1:0]]) begin
                sel[idx[PTR_W-1:0]] = 1'b1;
                done                = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        eligible = '0;
        starved  = '0;
        affine   = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            // Reset suppresses grants combinationally, not just via state.
            eligible[i] = req_valid[i] & issue_ready & ~RST;
            starved[i]  = eligible[i] && (wait_cnt[i] >= WAIT_W'(STARVE_LIMIT));
            affine[i]   = eligible[i] & last_div_valid & req_op[i][2]
                        & (req_op[i][0] == last_div_unsigned)
                        & (req_A_PR[i] == last_div_A_PR)
                        & (req_B_PR[i] == last_div_B_PR);
        end
    end

    always_comb begin
        grant       = '0;
        by_affinity = 1'b0;
        if (|starved) begin
            grant = first_from_ptr(starved, rr_ptr);
        end else if (|affine) begin
            grant       = first_from_ptr(affine, rr_ptr);
            by_affinity = 1'b1;
        end else begin
            grant = first_from_ptr(eligible, rr_ptr);
        end
        grant_valid = |grant;
    end

    // ------------------------------------------------------------------
    // Issue mux: OR of the one-hot-selected requester, all-zero with no grant.
    // ------------------------------------------------------------------
    always_comb begin
        win_idx         = '0;
        issue_op        = '0;
        issue_A_forward = 1'b0;
        issue_A_is_zero = 1'b0;
        issue_B_forward = 1'b0;
        issue_B_is_zero = 1'b0;
        win_A_PR        = '0;
        win_B_PR        = '0;
        issue_dest_PR   = '0;
        issue_ROB_index = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (grant[i]) begin
                win_idx         = PTR_W'(i);
                issue_op        = req_op[i];
                issue_A_forward = req_A_forward[i];
                issue_A_is_zero = req_A_is_zero[i];
                issue_B_forward = req_B_forward[i];
                issue_B_is_zero = req_B_is_zero[i];
                win_A_PR        = req_A_PR[i];
                win_B_PR        = req_B_PR[i];
                issue_dest_PR   = req_dest_PR[i];
                issue_ROB_index = req_ROB_index[i];
            end
        end
    end

    assign req_ready   = grant;
    assign issue_valid = grant_valid;
    assign issue_A_PR  = win_A_PR[LOG_PRF_BANK_COUNT-1:0];
    assign issue_B_PR  = win_B_PR[LOG_PRF_BANK_COUNT-1:0];

    assign rr_next = (win_idx == PTR_W'(REQ_COUNT-1)) ? '0 : win_idx + PTR_W'(1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr            <= '0;
            wait_cnt          <= '0;
            last_div_valid    <= 1'b0;
            last_div_unsigned <= 1'b0;
            last_div_A_PR     <= '0;
            last_div_B_PR     <= '0;
            affinity_hits     <= '0;
        end else begin
            if (grant_valid)
                rr_ptr <= rr_next;

            // A dropped request always clears; otherwise a loser counts up only
            // while the pipeline is accepting, and holds through a stall.
            for (int i = 0; i < REQ_COUNT; i++) begin
                if (!req_valid[i] || grant[i])
                    wait_cnt[i] <= '0;
                else if (issue_ready && (wait_cnt[i] != '1))
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
            end

            // A stall keeps pipeline adjacency; a bubble or a multiply breaks it.
            if (grant_valid) begin
                if (issue_op[2]) begin
                    last_div_valid    <= 1'b1;
                    last_div_unsigned <= issue_op[0];
                    last_div_A_PR     <= win_A_PR;
                    last_div_B_PR     <= win_B_PR;
                end else begin
                    last_div_valid <= 1'b0;
                end
            end else if (issue_ready) begin
                last_div_valid <= 1'b0;
            end

            if (by_affinity && (affinity_hits != 16'hFFFF))
                affinity_hits <= affinity_hits + 16'd1;
        end
    end

endmodule

// File: tb/tb_mdu_issue_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mdu_issue_arbiter
//
// Directed bench for mdu_issue_arbiter (REQ_COUNT=2). Each step drives one
// cycle of requests, pushes the expected issue-port image (winner chosen by
// the step itself) onto a scoreboard queue, and pops/compares it at the
// falling edge. affinity_hits is checked against hand-derived counts.
// -----------------------------------------------------------------------------
module tb_mdu_issue_arbiter;

    localparam int REQ_COUNT = 2;
    localparam int LOG_PR    = 7;
    localparam int LOG_ROB   = 6;
    localparam int LOG_BANK  = 2;
    localparam int EXP_W     = REQ_COUNT + 1 + 3 + 4 + 2*LOG_BANK + LOG_PR + LOG_ROB;

    localparam logic [2:0] MUL  = 3'b000;
    localparam logic [2:0] DIV  = 3'b100;
    localparam logic [2:0] DIVU = 3'b101;
    localparam logic [2:0] REM  = 3'b110;

    logic                                CLK;
    logic                                RST;
    logic [REQ_COUNT-1:0]                req_valid;
    logic [REQ_COUNT-1:0][2:0]           req_op;
    logic [REQ_COUNT-1:0]                req_A_forward;
    logic [REQ_COUNT-1:0]                req_A_is_zero;
    logic [REQ_COUNT-1:0]                req_B_forward;
    logic [REQ_COUNT-1:0]                req_B_is_zero;
    logic [REQ_COUNT-1:0][LOG_PR-1:0]    req_A_PR;
    logic [REQ_COUNT-1:0][LOG_PR-1:0]    req_B_PR;
    logic [REQ_COUNT-1:0][LOG_PR-1:0]    req_dest_PR;
    logic [REQ_COUNT-1:0][LOG_ROB-1:0]   req_ROB_index;
    logic [REQ_COUNT-1:0]                req_ready;
    logic                                issue_valid;
    logic [2:0]                          issue_op;
    logic                                issue_A_forward;
    logic                                issue_A_is_zero;
    logic [LOG_BANK-1:0]                 issue_A_PR;
    logic                                issue_B_forward;
    logic                                issue_B_is_zero;
    logic [LOG_BANK-1:0]                 issue_B_PR;
    logic [LOG_PR-1:0]                   issue_dest_PR;
    logic [LOG_ROB-1:0]                  issue_ROB_index;
    logic                                issue_ready;
    logic [15:0]                         affinity_hits;

    typedef struct {
        string            tag;
        logic [EXP_W-1:0] vec;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mdu_issue_arbiter #(
        .REQ_COUNT(REQ_COUNT), .STARVE_LIMIT(6), .WAIT_W(3),
        .LOG_PR_COUNT(LOG_PR), .LOG_ROB_ENTRIES(LOG_ROB), .LOG_PRF_BANK_COUNT(LOG_BANK)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .req_valid       (req_valid),
        .req_op          (req_op),
        .req_A_forward   (req_A_forward),
        .req_A_is_zero   (req_A_is_zero),
        .req_B_forward   (req_B_forward),
        .req_B_is_zero   (req_B_is_zero),
        .req_A_PR        (req_A_PR),
        .req_B_PR        (req_B_PR),
        .req_dest_PR     (req_dest_PR),
        .req_ROB_index   (req_ROB_index),
        .req_ready       (req_ready),
        .issue_valid     (issue_valid),
        .issue_op        (issue_op),
        .issue_A_forward (issue_A_forward),
        .issue_A_is_zero (issue_A_is_zero),
        .issue_A_PR      (issue_A_PR),
        .issue_B_forward (issue_B_forward),
        .issue_B_is_zero (issue_B_is_zero),
        .issue_B_PR      (issue_B_PR),
        .issue_dest_PR   (issue_dest_PR),
        .issue_ROB_index (issue_ROB_index),
        .issue_ready     (issue_ready),
        .affinity_hits   (affinity_hits)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Expected issue-port image when requester w wins (w < 0: no grant).
    function automatic logic [EXP_W-1:0] expect_vec(input int w);
        logic [REQ_COUNT-1:0] rdy;
        if (w < 0)
            return '0;
        rdy    = '0;
        rdy[w] = 1'b1;
        return {rdy, 1'b1, req_op[w],
                req_A_forward[w], req_A_is_zero[w], req_B_forward[w], req_B_is_zero[w],
                req_A_PR[w][LOG_BANK-1:0], req_B_PR[w][LOG_BANK-1:0],
                req_dest_PR[w], req_ROB_index[w]};
    endfunction

    function automatic logic [EXP_W-1:0] observed_vec();
        return {req_ready, issue_valid, issue_op,
                issue_A_forward, issue_A_is_zero, issue_B_forward, issue_B_is_zero,
                issue_A_PR, issue_B_PR, issue_dest_PR, issue_ROB_index};
    endfunction

    // One cycle: drive, queue the expectation, compare at negedge, advance.
    task automatic step(
        input string      tag,
        input logic       rst,
        input logic       ir,
        input logic       v0, input logic [2:0] o0,
        input logic [LOG_PR-1:0] a0, input logic [LOG_PR-1:0] b0,
        input logic       v1, input logic [2:0] o1,
        input logic [LOG_PR-1:0] a1, input logic [LOG_PR-1:0] b1,
        input int         exp_w
    );
        exp_t             e;
        logic [EXP_W-1:0] got;
        RST          = rst;
        issue_ready  = ir;
        req_valid    = {v1, v0};
        req_op[0]    = o0;
        req_op[1]    = o1;
        req_A_PR[0]  = a0;
        req_B_PR[0]  = b0;
        req_A_PR[1]  = a1;
        req_B_PR[1]  = b1;
        e.tag = tag;
        e.vec = expect_vec(exp_w);
        sb_q.push_back(e);
        @(negedge CLK);
        got = observed_vec();
        e   = sb_q.pop_front();
        n_checks++;
        assert (got === e.vec) n_pass++;
        else $error("FAIL %s: observed %h expected %h", e.tag, got, e.vec);
        @(posedge CLK);
        #1;
    endtask

    task automatic check_hits(input string tag, input logic [15:0] exp_hits);
        n_checks++;
        assert (affinity_hits === exp_hits) n_pass++;
        else $error("FAIL %s: affinity_hits observed %0d expected %0d", tag, affinity_hits, exp_hits);
    endtask

    initial begin
        RST           = 1'b1;
        issue_ready   = 1'b0;
        req_valid     = '0;
        req_op        = '0;
        req_A_PR      = '0;
        req_B_PR      = '0;
        // Distinct per-requester fields so the mux source is visible.
        req_A_forward = 2'b10;
        req_A_is_zero = 2'b01;
        req_B_forward = 2'b01;
        req_B_is_zero = 2'b10;
        req_dest_PR[0]   = 7'h21;
        req_dest_PR[1]   = 7'h32;
        req_ROB_index[0] = 6'h05;
        req_ROB_index[1] = 6'h2A;
        @(posedge CLK);
        #1;

        // Reset: no grant even with valid requests and a ready pipeline.
        step("rst_hold0", 1, 1, 1, MUL, 1, 2, 1, MUL, 3, 4, -1);
        step("rst_hold1", 1, 1, 1, MUL, 1, 2, 1, MUL, 3, 4, -1);
        check_hits("hits_after_reset", 16'd0);

        // Round-robin between two multiplies.
        step("rr_0", 0, 1, 1, MUL, 1, 2, 1, MUL, 3, 4, 0);
        step("rr_1", 0, 1, 1, MUL, 1, 2, 1, MUL, 3, 4, 1);
        step("rr_2", 0, 1, 1, MUL, 1, 2, 1, MUL, 3, 4, 0);
        step("rr_3", 0, 1, 1, MUL, 1, 2, 1, MUL, 3, 4, 1);
        check_hits("hits_rr", 16'd0);
        step("idle_a", 0, 1, 0, MUL, 0, 0, 0, MUL, 0, 0, -1);

        // Affinity: REM matching the last DIV beats the mul at rr_ptr=0.
        step("aff_seed", 0, 1, 0, MUL, 0, 0, 1, DIV, 5, 9, 1);
        step("aff_hit",  0, 1, 1, MUL, 5, 9, 1, REM, 5, 9, 1);
        check_hits("hits_aff", 16'd1);
        step("idle_b", 0, 1, 0, MUL, 0, 0, 0, MUL, 0, 0, -1);

        // Bubble breaks adjacency: round-robin picks the mul.
        step("bub_seed", 0, 1, 0, MUL, 0, 0, 1, DIV, 5, 9, 1);
        step("bub_gap",  0, 1, 0, MUL, 0, 0, 0, MUL, 0, 0, -1);
        step("bub_rr",   0, 1, 1, MUL, 1, 2, 1, DIV, 5, 9, 0);
        check_hits("hits_bubble", 16'd1);
        step("idle_c", 0, 1, 0, MUL, 0, 0, 0, MUL, 0, 0, -1);

        // Stall keeps adjacency: after 3 stalled cycles the DIVU wins.
        step("stl_seed", 0, 1, 0, MUL, 0, 0, 1, DIVU, 3, 4, 1);
        for (int k = 0; k < 3; k++)
            step("stl_hold", 0, 0, 1, MUL, 1, 2, 1, DIVU, 3, 4, -1);
        step("stl_hit",  0, 1, 1, MUL, 1, 2, 1, DIVU, 3, 4, 1);
        check_hits("hits_stall", 16'd2);

        // Signedness mismatch (last was DIVU, now DIV): no affinity.
        step("sgn_miss", 0, 1, 1, MUL, 1, 2, 1, DIV, 3, 4, 0);
        check_hits("hits_sign", 16'd2);
        step("idle_d", 0, 1, 0, MUL, 0, 0, 0, MUL, 0, 0, -1);

        // Starvation: req1 wins six times by affinity, then req0 is forced.
        step("stv_seed", 0, 1, 0, MUL, 0, 0, 1, DIV, 7, 8, 1);
        for (int k = 0; k < 6; k++)
            step("stv_aff", 0, 1, 1, MUL, 1, 2, 1, DIV, 7, 8, 1);
        check_hits("hits_pre_starve", 16'd8);
        step("stv_win",   0, 1, 1, MUL, 1, 2, 1, DIV, 7, 8, 0);
        check_hits("hits_starve", 16'd8);
        // req0's counter is clear again and the mul broke adjacency: plain RR.
        step("stv_after", 0, 1, 1, MUL, 1, 2, 1, DIV, 7, 8, 1);
        step("stv_reaff", 0, 1, 1, MUL, 1, 2, 1, DIV, 7, 8, 1);
        check_hits("hits_reaff", 16'd9);

        // Synchronous reset mid-stream restores rr_ptr=0 and clears the count.
        step("pre_rst",  0, 1, 1, MUL, 1, 2, 0, MUL, 0, 0, 0);
        step("mid_rst",  1, 1, 1, MUL, 1, 2, 1, MUL, 3, 4, -1);
        step("post_rst", 0, 1, 1, MUL, 1, 2, 1, MUL, 3, 4, 0);
        check_hits("hits_post_reset", 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_issue_arbiter.md
# mdu_issue_arbiter

Shares the single mdu_pipeline issue port between REQ_COUNT MDU issue queues. Each cycle it selects at most one requester and forwards that requester's issue fields to the pipeline in the same cycle, with no added latency. Selection order is:

1. Starvation protection.
2. Divider-pairing affinity, which keeps matching DIV/REM ops back-to-back so the pipeline's divider result reuse can hit.
3. Round-robin.

## Interface
Parameters:
- REQ_COUNT, 2: number of requesting IQs (2..4).
- STARVE_LIMIT, 6: consecutive lost cycles before a requester is forced to win.
- WAIT_W, 3: wait-counter width; STARVE_LIMIT < 2^WAIT_W.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- req_valid  in  [REQ_COUNT]  requester has an op.
- req_op  in  [REQ_COUNT][2:0]  MDU op; bit2=1 is DIV/DIVU/REM/REMU; bit0 is unsigned.
- req_A_forward, req_A_is_zero, req_B_forward, req_B_is_zero  in  [REQ_COUNT]  operand flags.
- req_A_PR, req_B_PR  in  [REQ_COUNT][LOG_PR_COUNT]  full source PRs.
- req_dest_PR  in  [REQ_COUNT][LOG_PR_COUNT]  destination PR.
- req_ROB_index  in  [REQ_COUNT][LOG_ROB_ENTRIES]  ROB index.
- req_ready  out  [REQ_COUNT]  one-hot grant; the op is consumed this cycle.
- issue_valid, issue_op, issue_A_forward, issue_A_is_zero, issue_B_forward, issue_B_is_zero, issue_dest_PR, issue_ROB_index  out  pipeline issue fields; widths match mdu_pipeline.
- issue_A_PR, issue_B_PR  out  [LOG_PRF_BANK_COUNT]  bank bits of the winner's PRs.
- issue_ready  in  1  pipeline accepts an issue this cycle.
- affinity_hits  out  16  saturating count of grants decided by affinity.

## Operation
Eligibility:
- A requester is eligible when issue_ready=1 and its req_valid=1.
- When issue_ready=0 there is no grant, all req_ready=0 and issue_valid=0.

Priority among eligible requesters:
- **(1) Starved:** wait_cnt[i] >= STARVE_LIMIT. Scan starts at rr_ptr; the first hit wins.
- **(2) Affinity:** last_div_valid=1 and req_op[i][2]=1 and req_op[i][0]=last_div_unsigned and req_A_PR[i]=last_div_A_PR and req_B_PR[i]=last_div_B_PR. Scan starts at rr_ptr.
- **(3) Round-robin:** the first valid requester scanning from rr_ptr, wrapping at REQ_COUNT-1 to 0.

Grant:
- req_ready[w]=1 and issue_valid=1.
- All issue_* fields are a combinational mux of requester w.
- With no grant, issue_* data fields are 0.

State updates (registered, at posedge CLK):
- **rr_ptr:**
  - Becomes (w+1) mod REQ_COUNT on every grant.
  - Unchanged otherwise.
- **wait_cnt[i]:**
  - Cleared if req_valid[i]=0 or i was granted.
  - Saturating increment if req_valid[i]=1, issue_ready=1 and i lost.
  - Held if issue_ready=0.
- **last_div:**
  - On a grant of a div op: last_div_valid=1, and unsigned/A_PR/B_PR are captured.
  - On a grant of a mul op: last_div_valid=0.
  - On issue_ready=1 with no grant: last_div_valid=0, because a bubble breaks pipeline adjacency.
  - On issue_ready=0: held, because the pipeline stall preserves adjacency.
- **affinity_hits:** increments by 1 when the grant came from level (2) and no level-(1) requester existed; saturates at 16'hFFFF.

Reset, with RST=1 at posedge:
- rr_ptr=0, all wait_cnt=0, last_div_valid=0 and its fields=0, affinity_hits=0.
- While RST=1, req_ready=0 and issue_valid=0 combinationally.
- Reset mid-stall discards all state; no grant is issued during reset.

## Timing
- Zero-cycle grant path: req_valid/issue_ready to req_ready/issue_* is purely combinational. This is required because the forward flags are valid only in the request cycle.
- No buffering; the arbiter never holds an op.
- State changes are visible to arbitration the cycle after the triggering grant.
- Simultaneous starved and affinity candidates: starved wins, and affinity_hits does not increment.
- Multiple starved requesters: order is from rr_ptr.
- Requester dropping valid while waiting: its counter clears the next cycle.
- REQ_COUNT=2 wrap: rr_ptr toggles 0↔1.

## Test plan
- **Round-robin:** REQ_COUNT=2, both valid with mul ops, issue_ready=1 for 4 cycles -> grants 0,1,0,1; affinity_hits=0.
- **Affinity:** req0 DIV A_PR=5 B_PR=9 is granted. Next cycle req0 holds MUL, req1 holds REM A_PR=5 B_PR=9 (signed), rr_ptr=1 → 0? Rather: arrange rr_ptr pointing at the mul requester. Required: the REM requester wins and affinity_hits=1.
- **Bubble breaks affinity:** DIV granted, then one cycle with issue_ready=1 and no valid, then the matching DIV plus a competing mul at rr_ptr -> the mul wins (round-robin); affinity_hits unchanged.
- **Stall holds affinity:** DIV granted, then issue_ready=0 for 3 cycles (req_ready=0, counters frozen), then issue_ready=1 -> the matching DIV wins via affinity.
- **Starvation:** req1 issues a repeating matching DIV stream that always wins affinity while req0 is valid with a mul -> req0 is granted on the cycle its wait_cnt reaches 6; its counter clears the next cycle.
- **Sync reset:** assert RST=1 for 1 cycle mid-stream with both valid -> issue_valid=0 and req_ready=00 during reset; the first post-reset grant goes to req0; affinity_hits=0.
